// File: rtl/rate_sched.sv
// rate_sched: sequences decimation-factor changes for a downsampler.
//   A free-running divider produces a one-cycle 48 kHz strobe (en48k).
//   A rate-change request is accepted only in RUN. When it differs from the
//   current factor, the FSM waits in PEND for a frame boundary (ds_en_in) or
//   a 16-strobe timeout. It then flushes the downsampler for one cycle
//   (ds_reset, new nfreq_out, frame_cnt cleared) and settles until the next
//   output frame.
// Ports:
//   clock      master clock (rising edge)
//   reset      asynchronous active-low reset
//   nfreq_req  requested decimation factor (0 is treated as 1)
//   req_valid  rate-change request strobe
//   req_ready  high only in RUN
//   en48k      48 kHz sample strobe, suppressed during FLUSH
//   nfreq_out  decimation factor driven to the downsampler
//   ds_reset   one-cycle synchronous reset pulse to the downsampler
//   ds_en_in   downsampler output strobe
//   frame_cnt  output frames since the last rate change
//   state_out  FSM state: RUN=0, PEND=1, FLUSH=2, SETTLE=3
module rate_sched #(
  parameter int unsigned DIV     = 2048,
  parameter int unsigned NF_INIT = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  nfreq_req,
  input  logic        req_valid,
  output logic        req_ready,
  output logic        en48k,
  output logic [3:0]  nfreq_out,
  output logic        ds_reset,
  input  logic        ds_en_in,
  output logic [15:0] frame_cnt,
  output logic [1:0]  state_out
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    PEND   = 2'd1,
    FLUSH  = 2'd2,
    SETTLE = 2'd3
  } state_t;

  localparam logic [15:0] DIV_M1 = 16'(DIV - 1);
  localparam logic [3:0]  NF_RST = 4'(NF_INIT);

  state_t      r_state, w_state_nxt;
  logic [15:0] r_div, w_div_nxt;
  logic [4:0]  r_to, w_to_nxt;
  logic [3:0]  r_pend, w_pend_nxt;
  logic [3:0]  r_nf, w_nf_nxt;
  logic [15:0] r_fc, w_fc_nxt;
  logic        r_en, w_en_nxt;
  logic        r_ready, w_ready_nxt;
  logic        r_dsr, w_dsr_nxt;

  logic [3:0]  w_clamped;
  logic        w_accept;
  logic        w_timeout;

  assign w_clamped = (nfreq_req == 4'd0) ? 4'd1 : nfreq_req;
  assign w_accept  = req_valid && (r_state == RUN);
  // The 16th strobe seen in PEND ends the wait on the same edge it is counted.
  assign w_timeout = r_en && (r_to == 5'd15);
  assign w_div_nxt = (r_div == DIV_M1) ? '0 : r_div + 16'd1;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= FLUSH;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      RUN:    if (w_accept && (w_clamped != r_nf)) w_state_nxt = PEND;
      PEND:   if (ds_en_in || w_timeout)           w_state_nxt = FLUSH;
      FLUSH:                                       w_state_nxt = SETTLE;
      SETTLE: if (ds_en_in)                        w_state_nxt = RUN;
      default:                                     w_state_nxt = FLUSH;
    endcase
  end

  // Output / datapath next values; every output is taken from a register,
  // so the flags are decoded from the next state rather than the current one.
  always_comb begin
    w_en_nxt    = (w_div_nxt == DIV_M1) && (w_state_nxt != FLUSH);
    w_ready_nxt = (w_state_nxt == RUN);
    w_dsr_nxt   = (w_state_nxt == FLUSH);
    w_pend_nxt  = r_pend;
    w_nf_nxt    = r_nf;
    w_to_nxt    = r_to;
    w_fc_nxt    = r_fc;

    if (w_accept) w_pend_nxt = w_clamped;

    if ((r_state == PEND) && r_en) w_to_nxt = r_to + 5'd1;

    if (ds_en_in) w_fc_nxt = r_fc + 16'd1;

    if (r_state == FLUSH) begin
      w_nf_nxt = r_pend;
      w_fc_nxt = '0;
      w_to_nxt = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_div   <= '0;
      r_to    <= '0;
      r_pend  <= NF_RST;
      r_nf    <= NF_RST;
      r_fc    <= '0;
      r_en    <= 1'b0;
      r_ready <= 1'b0;
      r_dsr   <= 1'b1;
    end else begin
      r_div   <= w_div_nxt;
      r_to    <= w_to_nxt;
      r_pend  <= w_pend_nxt;
      r_nf    <= w_nf_nxt;
      r_fc    <= w_fc_nxt;
      r_en    <= w_en_nxt;
      r_ready <= w_ready_nxt;
      r_dsr   <= w_dsr_nxt;
    end
  end

  assign req_ready = r_ready;
  assign en48k     = r_en;
  assign nfreq_out = r_nf;
  assign ds_reset  = r_dsr;
  assign frame_cnt = r_fc;
  assign state_out = r_state;

endmodule

// File: tb/tb_rate_sched.sv
module tb_rate_sched;

  localparam int unsigned DIV     = 4;
  localparam int unsigned NF_INIT = 1;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  nfreq_req = '0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        en48k;
  logic [3:0]  nfreq_out;
  logic        ds_reset;
  logic        ds_en_in = 1'b0;
  logic [15:0] frame_cnt;
  logic [1:0]  state_out;

  rate_sched #(.DIV(DIV), .NF_INIT(NF_INIT)) dut (
    .clock     (clock),
    .reset     (reset),
    .nfreq_req (nfreq_req),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .en48k     (en48k),
    .nfreq_out (nfreq_out),
    .ds_reset  (ds_reset),
    .ds_en_in  (ds_en_in),
    .frame_cnt (frame_cnt),
    .state_out (state_out)
  );

  always #5 clock = ~clock;

  typedef struct {
    int st;
    int rdy;
    int dsr;
    int en;
    int nf;
    int fc;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int n_dsr_pulses = 0;

  // Reference model: state named by its spec encoding, time by edge count.
  int m_st, m_nf, m_pend, m_fc, m_to, m_en;
  int m_k;

  function automatic void chk(string name, int act, int expv);
    n_checks++;
    if (act != expv) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endfunction

  function automatic void model_reset();
    m_st = 2; m_nf = NF_INIT; m_pend = NF_INIT;
    m_fc = 0; m_to = 0; m_en = 0; m_k = 0;
  endfunction

  function automatic void model_step(int rv, int nr, int de);
    int ns, c;
    ns = m_st;
    case (m_st)
      0: if (rv != 0) begin
           c = (nr == 0) ? 1 : nr;
           m_pend = c;
           if (c != m_nf) ns = 1;
         end
      1: begin
           // leave on a frame boundary or on the 16th strobe seen while waiting
           if (de != 0 || (m_en != 0 && m_to + 1 >= 16)) ns = 2;
           if (m_en != 0) m_to++;
         end
      2: ns = 3;
      3: if (de != 0) ns = 0;
      default: ns = 2;
    endcase
    if (m_st == 2) begin
      m_nf = m_pend; m_fc = 0; m_to = 0;
    end else if (de != 0) begin
      m_fc = (m_fc + 1) % 65536;
    end
    m_k++;
    m_en = ((m_k % DIV) == DIV - 1 && ns != 2) ? 1 : 0;
    m_st = ns;
  endfunction

  function automatic void push_exp();
    exp_t e;
    e.st = m_st; e.rdy = (m_st == 0); e.dsr = (m_st == 2);
    e.en = m_en; e.nf = m_nf; e.fc = m_fc;
    exp_q.push_back(e);
  endfunction

  // One clock: inputs applied after the falling edge, model advanced at the
  // rising edge, expectation queued for the monitor.
  task automatic cycle(input int rv, input int nr, input int de, input int rst_n);
    @(negedge clock);
    #1;
    req_valid = rv[0];
    nfreq_req = nr[3:0];
    ds_en_in  = de[0];
    reset     = rst_n[0];
    @(posedge clock);
    if (rst_n == 0) model_reset();
    else            model_step(rv, nr, de);
    push_exp();
  endtask

  task automatic go_run();
    int n = 0;
    while (m_st != 0 && n < 200) begin
      cycle(0, 0, (m_st == 3) ? 1 : 0, 1);
      n++;
    end
    chk("reach_run", m_st, 0);
  endtask

  // Monitor: compares every cycle the DUT presents against the queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("state",     int'(state_out), e.st);
        chk("req_ready", int'(req_ready), e.rdy);
        chk("ds_reset",  int'(ds_reset),  e.dsr);
        chk("en48k",     int'(en48k),     e.en);
        chk("nfreq_out", int'(nfreq_out), e.nf);
        chk("frame_cnt", int'(frame_cnt), e.fc);
        if (ds_reset && reset) n_dsr_pulses++;
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish, errors %0d", n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, n;
    model_reset();

    // reset held, then release: FLUSH, SETTLE, RUN on first frame
    repeat (3) cycle(0, 0, 0, 0);
    repeat (6) cycle(0, 0, 0, 1);
    go_run();

    // request 3, frame boundary two cycles later
    cycle(1, 3, 0, 1);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 1, 1);
    repeat (3) cycle(0, 0, 0, 1);
    chk("nf_after_3", m_nf, 3);
    go_run();

    // timeout: no frame boundary while pending
    cycle(1, 5, 0, 1);
    n = 0;
    while (m_st == 1 && n < 100) begin cycle(0, 0, 0, 1); n++; end
    chk("timeout_exit", m_st, 2);
    go_run();

    // request 0 clamps to 1; equal request stays in RUN
    cycle(1, 0, 0, 1);
    cycle(0, 0, 1, 1);
    go_run();
    p0 = n_dsr_pulses;
    cycle(1, 1, 0, 1);
    repeat (4) cycle(0, 0, 0, 1);
    chk("equal_req_no_flush", n_dsr_pulses - p0, 0);

    // request in PEND is ignored
    cycle(1, 9, 0, 1);
    repeat (3) cycle(1, 4, 0, 1);
    cycle(0, 0, 1, 1);
    go_run();

    // frame boundary coincides with timeout: one flush pulse
    p0 = n_dsr_pulses;
    cycle(1, 6, 0, 1);
    n = 0;
    while (m_st == 1 && n < 100) begin
      cycle(0, 0, (m_en != 0 && m_to == 15) ? 1 : 0, 1);
      n++;
    end
    repeat (3) cycle(0, 0, 0, 1);
    chk("coincide_one_pulse", n_dsr_pulses - p0, 1);
    go_run();

    // reset mid-PEND with 7 pending
    cycle(1, 7, 0, 1);
    repeat (3) cycle(0, 0, 0, 1);
    repeat (2) cycle(0, 0, 0, 0);
    repeat (3) cycle(0, 0, 0, 1);
    go_run();

    // frame counter wrap while in RUN
    repeat (65536) cycle(0, 0, 1, 1);

    // randomized traffic
    for (int i = 0; i < 3000; i++)
      cycle(($urandom_range(0, 9) == 0) ? 1 : 0, $urandom_range(0, 15),
            ($urandom_range(0, 5) == 0) ? 1 : 0,
            ($urandom_range(0, 499) == 0) ? 0 : 1);

    repeat (2) @(negedge clock);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rate_sched.md
RATE_SCHED -- requirements
Module: rate_sched

Interface
REQ-001 Parameter DIV, default 2048, master-clock cycles per 48 kHz input sample period (legal 2..65535).
REQ-002 Parameter NF_INIT, default 1, decimation factor applied after reset (legal 1..15).
REQ-003 clock  in  1  master clock; all logic is clocked on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 nfreq_req  in  4  requested decimation factor.
REQ-006 req_valid  in  1  rate-change request strobe.
REQ-007 req_ready  out  1  high when a request can be accepted.
REQ-008 en48k  out  1  one-cycle 48 kHz sample strobe to the downsampler endatain.
REQ-009 nfreq_out  out  4  decimation factor driven to the downsampler Nfreq.
REQ-010 ds_reset  out  1  synchronous active-high reset pulse to the downsampler.
REQ-011 ds_en_in  in  1  downsampler output strobe (endataout).
REQ-012 frame_cnt  out  16  output frames since the last rate change.
REQ-013 state_out  out  2  current FSM state encoding: RUN=0, PEND=1, FLUSH=2, SETTLE=3.

Function
REQ-014 All outputs SHALL be registered.
REQ-015 A free-running divider SHALL count 0..DIV-1, wrap to 0, and never be cleared by ds_reset or by FSM activity.
REQ-016 en48k SHALL be 1 for exactly one cycle when the divider equals DIV-1, except in FLUSH, where it is held 0 and that strobe is not reissued.
REQ-017 req_ready SHALL equal 1 only in RUN.
REQ-018 A request SHALL be accepted on a cycle with req_valid=1 and req_ready=1; req_valid at other times is ignored and not queued.
REQ-019 On acceptance, nfreq_req=0 SHALL be clamped to 1 and latched as pending.
REQ-020 If the clamped value equals nfreq_out, the FSM SHALL stay in RUN with no restart and no frame_cnt change.
REQ-021 Otherwise the FSM SHALL move RUN->PEND.
REQ-022 In PEND, a 5-bit timeout counter SHALL count en48k strobes.
REQ-023 PEND->FLUSH SHALL occur on ds_en_in=1 (frame boundary) or when the timeout count reaches 16; both in the same cycle cause a single transition.
REQ-024 FLUSH SHALL last exactly one cycle with ds_reset=1; in that cycle nfreq_out <= pending, frame_cnt <= 0 and the timeout counter <= 0.
REQ-025 FLUSH->SETTLE SHALL be unconditional.
REQ-026 SETTLE->RUN SHALL occur on the first ds_en_in=1.
REQ-027 frame_cnt SHALL increment by 1 on every ds_en_in=1 outside FLUSH, wrapping 65535->0.
REQ-028 ds_reset SHALL be 0 in all states except FLUSH.

Reset
REQ-029 While reset=0: state=FLUSH, ds_reset=1, en48k=0, req_ready=0, nfreq_out=NF_INIT, frame_cnt=0, divider=0, timeout counter=0, pending=NF_INIT.
REQ-030 The first clock edge after reset release SHALL execute FLUSH (ds_reset high for that cycle), then proceed to SETTLE.
REQ-031 Reset asserted mid-PEND or mid-SETTLE SHALL discard the pending value immediately; nfreq_out returns to NF_INIT.

Verification (DIV=4, NF_INIT=1)
REQ-032 Reset release -> ds_reset high for 1 cycle, SETTLE, first ds_en_in -> RUN, req_ready=1; en48k every 4th cycle.
REQ-033 RUN, nfreq_req=3 with req_valid, ds_en_in 2 cycles later -> PEND, then FLUSH: nfreq_out=3, frame_cnt=0, en48k suppressed if due, then SETTLE.
REQ-034 PEND with ds_en_in held 0 -> FLUSH on the 16th en48k strobe (~64 cycles).
REQ-035 nfreq_req=0 -> nfreq_out becomes 1; nfreq_req equal to current nfreq_out -> state stays RUN, no ds_reset.
REQ-036 req_valid pulsed in PEND -> ignored, nfreq_out ends at the first request's value; ds_en_in and timeout coincide -> exactly one ds_reset pulse.
REQ-037 reset=0 mid-PEND with pending=7 -> nfreq_out=1 after release; 65536 ds_en_in strobes in RUN -> frame_cnt wraps to 0.
